fp_div_prep: RTL and testbench

- Parametrised front-end of the floating-point divider.
- Accepts one dividend/divisor pair through a valid/ready handshake and classifies both operands (zero, infinity, NaN, normal).
- Produces the result sign, the biased result exponent, and the hidden-bit mantissas for the downstream mantissa divider.
- Flags divide-by-zero, invalid operation, and exponent overflow/underflow. Holds the result until the consumer accepts it.

---
 rtl/fp_div_prep.sv | 210 +++++++++++++++++++++
 tb/tb_fp_div_prep.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/fp_div_prep.sv
// fp_div_prep: front end of the floating-point divider.
// Takes one dividend/divisor pair per valid/ready handshake, classifies both
// operands, and produces the result sign, the biased result exponent, and the
// hidden-bit mantissas for the mantissa divider. The result is held until the
// consumer takes it.
//
// Ports:
//   clk, res              clock (rising edge), async active-low reset
//   in_valid / in_ready   operand handshake (in_ready high only in IDLE)
//   divisible, divider    operands {sign, exponent, mantissa}, W bits each
//   out_valid / out_ready result handshake (out_valid high only in OUT)
//   sign, exponent        result sign, signed biased exponent (EXP_W+2 bits)
//   man_a, man_b          dividend / divisor mantissas with hidden bit
//   res_class             00 NORMAL, 01 ZERO, 10 INF, 11 NAN
//   div_by_zero, invalid, ovf, unf  exception flags
module fp_div_prep #(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10
) (
    input  logic                 clk,
    input  logic                 res,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] divisible,
    input  logic [EXP_W+MAN_W:0] divider,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 sign,
    output logic [EXP_W+1:0]     exponent,
    output logic [MAN_W:0]       man_a,
    output logic [MAN_W:0]       man_b,
    output logic [1:0]           res_class,
    output logic                 div_by_zero,
    output logic                 invalid,
    output logic                 ovf,
    output logic                 unf
);
    localparam int W = 1 + EXP_W + MAN_W;
    // Bias and all-ones exponent, pre-extended to the result exponent width.
    localparam logic [EXP_W+1:0] BIAS_X = {3'b000, {(EXP_W-1){1'b1}}};
    localparam logic [EXP_W+1:0] EMAX_X = {2'b00, {EXP_W{1'b1}}};

    localparam logic [1:0] CLS_NORMAL = 2'b00;
    localparam logic [1:0] CLS_ZERO   = 2'b01;
    localparam logic [1:0] CLS_INF    = 2'b10;
    localparam logic [1:0] CLS_NAN    = 2'b11;

    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, OUT = 2'd2} state_t;

    state_t state_q, state_d;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge res) begin
        if (!res) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)  state_d = CALC;
            CALC:                   state_d = OUT;
            OUT:     if (out_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == OUT);
    end

    // ---------------- operand capture ----------------
    logic [W-1:0] a_q, a_d, b_q, b_d;
    wire          accept = (state_q == IDLE) && in_valid;

    always_comb begin
        a_d = a_q;
        b_d = b_q;
        if (accept) begin
            a_d = divisible;
            b_d = divider;
        end
    end

    // ---------------- operand decode ----------------
    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] ma, mb;
    logic             a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;
    logic [EXP_W+1:0] exp_raw;

    always_comb begin
        ea     = a_q[W-2:MAN_W];
        eb     = b_q[W-2:MAN_W];
        ma     = a_q[MAN_W-1:0];
        mb     = b_q[MAN_W-1:0];
        // Exponent field 0 is zero regardless of mantissa: denormals flush.
        a_zero = (ea == '0);
        b_zero = (eb == '0);
        a_inf  = (&ea) && (ma == '0);
        b_inf  = (&eb) && (mb == '0);
        a_nan  = (&ea) && (ma != '0);
        b_nan  = (&eb) && (mb != '0);
        // Two extra bits hold the full range of ea-eb+BIAS without wrap.
        exp_raw = {2'b00, ea} - {2'b00, eb} + BIAS_X;
    end

    // ---------------- result computation ----------------
    logic             sign_q, sign_d;
    logic [EXP_W+1:0] exp_q, exp_d;
    logic [MAN_W:0]   man_a_q, man_a_d, man_b_q, man_b_d;
    logic [1:0]       cls_q, cls_d;
    logic             dbz_q, dbz_d, inv_q, inv_d, ovf_q, ovf_d, unf_q, unf_d;

    always_comb begin
        sign_d  = sign_q;
        exp_d   = exp_q;
        man_a_d = man_a_q;
        man_b_d = man_b_q;
        cls_d   = cls_q;
        dbz_d   = dbz_q;
        inv_d   = inv_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        if (accept) begin
            // Clear everything so a stale result never leaks into CALC.
            sign_d  = 1'b0;
            exp_d   = '0;
            man_a_d = '0;
            man_b_d = '0;
            cls_d   = CLS_NORMAL;
            dbz_d   = 1'b0;
            inv_d   = 1'b0;
            ovf_d   = 1'b0;
            unf_d   = 1'b0;
        end else if (state_q == CALC) begin
            sign_d  = a_q[W-1] ^ b_q[W-1];
            exp_d   = EMAX_X;
            man_a_d = '0;
            man_b_d = '0;
            dbz_d   = 1'b0;
            inv_d   = 1'b0;
            ovf_d   = 1'b0;
            unf_d   = 1'b0;
            // Priority order matters: NaN/indeterminate forms first.
            if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
                cls_d  = CLS_NAN;
                inv_d  = 1'b1;
                sign_d = 1'b0;
            end else if (a_inf) begin
                cls_d = CLS_INF;
            end else if (b_zero) begin
                cls_d = CLS_INF;
                dbz_d = 1'b1;
            end else if (a_zero || b_inf) begin
                cls_d = CLS_ZERO;
                exp_d = '0;
            end else begin
                cls_d   = CLS_NORMAL;
                exp_d   = exp_raw;
                man_a_d = {1'b1, ma};
                man_b_d = {1'b1, mb};
                // Range flags come from the raw signed exponent.
                ovf_d   = ($signed(exp_raw) >= $signed(EMAX_X));
                unf_d   = exp_raw[EXP_W+1] || (exp_raw == '0);
            end
        end
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            a_q     <= '0;
            b_q     <= '0;
            sign_q  <= 1'b0;
            exp_q   <= '0;
            man_a_q <= '0;
            man_b_q <= '0;
            cls_q   <= CLS_NORMAL;
            dbz_q   <= 1'b0;
            inv_q   <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            sign_q  <= sign_d;
            exp_q   <= exp_d;
            man_a_q <= man_a_d;
            man_b_q <= man_b_d;
            cls_q   <= cls_d;
            dbz_q   <= dbz_d;
            inv_q   <= inv_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign sign        = sign_q;
    assign exponent    = exp_q;
    assign man_a       = man_a_q;
    assign man_b       = man_b_q;
    assign res_class   = cls_q;
    assign div_by_zero = dbz_q;
    assign invalid     = inv_q;
    assign ovf         = ovf_q;
    assign unf         = unf_q;

endmodule

// File: tb/tb_fp_div_prep.sv
// Scoreboard bench for fp_div_prep (EXP_W=5, MAN_W=10, BIAS=15).
// The driver pushes hand-computed expected results; a monitor pops and
// compares whenever out_valid rises.
module tb_fp_div_prep;
    localparam int EXP_W = 5;
    localparam int MAN_W = 10;
    localparam int W     = 1 + EXP_W + MAN_W;

    logic             clk = 1'b0;
    logic             res = 1'b0;
    logic             in_valid = 1'b0;
    logic             out_ready = 1'b0;
    logic [W-1:0]     divisible = '0;
    logic [W-1:0]     divider = '0;
    logic             in_ready, out_valid, sign;
    logic [EXP_W+1:0] exponent;
    logic [MAN_W:0]   man_a, man_b;
    logic [1:0]       res_class;
    logic             div_by_zero, invalid, ovf, unf;

    fp_div_prep #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
        .clk(clk), .res(res),
        .in_valid(in_valid), .in_ready(in_ready),
        .divisible(divisible), .divider(divider),
        .out_valid(out_valid), .out_ready(out_ready),
        .sign(sign), .exponent(exponent), .man_a(man_a), .man_b(man_b),
        .res_class(res_class), .div_by_zero(div_by_zero), .invalid(invalid),
        .ovf(ovf), .unf(unf)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        s;
        logic [6:0]  e;
        logic [10:0] ma;
        logic [10:0] mb;
        logic [1:0]  c;
        logic        dz, iv, ov, un;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, want);
        end
    endtask

    task automatic chk_fields(input string tag, input exp_t e);
        chk({tag, " sign"},      32'(sign),        32'(e.s));
        chk({tag, " exponent"},  32'(exponent),    32'(e.e));
        chk({tag, " man_a"},     32'(man_a),       32'(e.ma));
        chk({tag, " man_b"},     32'(man_b),       32'(e.mb));
        chk({tag, " res_class"}, 32'(res_class),   32'(e.c));
        chk({tag, " dbz"},       32'(div_by_zero), 32'(e.dz));
        chk({tag, " invalid"},   32'(invalid),     32'(e.iv));
        chk({tag, " ovf"},       32'(ovf),         32'(e.ov));
        chk({tag, " unf"},       32'(unf),         32'(e.un));
    endtask

    function automatic exp_t mk(input logic s, input logic [6:0] e, input logic [10:0] ma,
                                input logic [10:0] mb, input logic [1:0] c, input logic dz,
                                input logic iv, input logic ov, input logic un);
        exp_t r;
        r.s = s; r.e = e; r.ma = ma; r.mb = mb; r.c = c;
        r.dz = dz; r.iv = iv; r.ov = ov; r.un = un;
        return r;
    endfunction

    // Monitor: compare on every rising edge of out_valid.
    logic prev_ov = 1'b0;
    exp_t mon_e;
    always @(negedge clk) begin
        if (out_valid && !prev_ov) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out: got out_valid=1 expected no pending result");
            end else begin
                mon_e = q.pop_front();
                chk_fields("mon", mon_e);
            end
        end
        prev_ov = out_valid;
    end

    // One full transaction with optional backpressure hold in OUT.
    task automatic do_op(input logic [15:0] a, input logic [15:0] b, input exp_t e, input int hold);
        @(negedge clk);
        chk("idle in_ready", 32'(in_ready), 1);
        in_valid = 1'b1; divisible = a; divider = b;
        q.push_back(e);
        @(negedge clk);                       // accepting edge passed: CALC
        in_valid = 1'b0;
        divisible = 16'($urandom); divider = 16'($urandom);
        chk("calc in_ready", 32'(in_ready), 0);
        chk("calc out_valid", 32'(out_valid), 0);
        @(negedge clk);                       // OUT
        chk("latency out_valid", 32'(out_valid), 1);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;                  // must be ignored in OUT
            divisible = 16'($urandom); divider = 16'($urandom);
            @(negedge clk);
            chk("hold out_valid", 32'(out_valid), 1);
            chk("hold in_ready", 32'(in_ready), 0);
            chk("hold exponent", 32'(exponent), 32'(e.e));
            chk("hold man_a", 32'(man_a), 32'(e.ma));
            chk("hold class", 32'(res_class), 32'(e.c));
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("release in_ready", 32'(in_ready), 1);
        chk("release out_valid", 32'(out_valid), 0);
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst in_ready", 32'(in_ready), 1);
        chk("rst out_valid", 32'(out_valid), 0);
        chk("rst exponent", 32'(exponent), 0);
        chk("rst man_a", 32'(man_a), 0);
        chk("rst class", 32'(res_class), 0);
        res = 1'b1;
        @(negedge clk);

        //           sign e      man_a   man_b   cls    dz iv ov un
        do_op(16'h3C00, 16'h3C00, mk(0, 7'd15, 11'h400, 11'h400, 2'b00, 0, 0, 0, 0), 0);
        do_op(16'hC600, 16'h4000, mk(1, 7'd16, 11'h600, 11'h400, 2'b00, 0, 0, 0, 0), 0);
        do_op(16'h3C00, 16'h0000, mk(0, 7'd31, 11'h000, 11'h000, 2'b10, 1, 0, 0, 0), 0);
        do_op(16'h0000, 16'h0000, mk(0, 7'd31, 11'h000, 11'h000, 2'b11, 0, 1, 0, 0), 0);
        do_op(16'h7C00, 16'h7C00, mk(0, 7'd31, 11'h000, 11'h000, 2'b11, 0, 1, 0, 0), 0);
        do_op(16'h7E00, 16'h3C00, mk(0, 7'd31, 11'h000, 11'h000, 2'b11, 0, 1, 0, 0), 0);
        do_op(16'h7800, 16'h0400, mk(0, 7'd44, 11'h400, 11'h400, 2'b00, 0, 0, 1, 0), 0);
        do_op(16'h0400, 16'h7800, mk(0, 7'h72, 11'h400, 11'h400, 2'b00, 0, 0, 0, 1), 0);
        do_op(16'h3C00, 16'h7C00, mk(0, 7'd0,  11'h000, 11'h000, 2'b01, 0, 0, 0, 0), 0);
        do_op(16'hFC00, 16'h3C00, mk(1, 7'd31, 11'h000, 11'h000, 2'b10, 0, 0, 0, 0), 0);
        do_op(16'h8000, 16'h4000, mk(1, 7'd0,  11'h000, 11'h000, 2'b01, 0, 0, 0, 0), 0);
        do_op(16'h0001, 16'h3C00, mk(0, 7'd0,  11'h000, 11'h000, 2'b01, 0, 0, 0, 0), 0);
        do_op(16'h3C00, 16'h0200, mk(0, 7'd31, 11'h000, 11'h000, 2'b10, 1, 0, 0, 0), 0);
        // Backpressure: held 5 clocks in OUT
        do_op(16'hBC00, 16'h3C00, mk(1, 7'd15, 11'h400, 11'h400, 2'b00, 0, 0, 0, 0), 5);

        // Reset during CALC: operation dropped, nothing expected
        @(negedge clk);
        in_valid = 1'b1; divisible = 16'h3C00; divider = 16'h3C00;
        @(negedge clk);
        in_valid = 1'b0;
        res = 1'b0;
        #1;
        chk("rst_calc out_valid", 32'(out_valid), 0);
        chk("rst_calc in_ready", 32'(in_ready), 1);
        chk("rst_calc exponent", 32'(exponent), 0);
        @(negedge clk);
        res = 1'b1;
        do_op(16'h3C00, 16'h3C00, mk(0, 7'd15, 11'h400, 11'h400, 2'b00, 0, 0, 0, 0), 0);

        // Reset during OUT: held result zeroed at once
        @(negedge clk);
        in_valid = 1'b1; divisible = 16'h7800; divider = 16'h0400;
        q.push_back(mk(0, 7'd44, 11'h400, 11'h400, 2'b00, 0, 0, 1, 0));
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        res = 1'b0;
        #1;
        chk("rst_out out_valid", 32'(out_valid), 0);
        chk("rst_out exponent", 32'(exponent), 0);
        chk("rst_out man_a", 32'(man_a), 0);
        chk("rst_out ovf", 32'(ovf), 0);
        chk("rst_out in_ready", 32'(in_ready), 1);
        @(negedge clk);
        res = 1'b1;
        do_op(16'hC600, 16'h4000, mk(1, 7'd16, 11'h600, 11'h400, 2'b00, 0, 0, 0, 0), 0);

        repeat (2) @(negedge clk);
        chk("scoreboard drained", 32'(q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Safety net so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish within bound");
        $fatal(1, "timeout");
    end
endmodule
